// File: rtl/pc_pkg.sv
// Shared definitions for the fetch-stage program-counter unit.
package pc_pkg;

    // Sequencer state codes, visible on State_o.
    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_HALT = 2'b10
    } pc_state_e;

    // Where the next PC comes from; usable by hazard/debug logic.
    typedef enum logic [2:0] {
        SRC_HOLD   = 3'd0,
        SRC_SEQ    = 3'd1,
        SRC_TRAP   = 3'd2,
        SRC_RET    = 3'd3,
        SRC_JUMP   = 3'd4,
        SRC_BRANCH = 3'd5,
        SRC_RESET  = 3'd6
    } pc_src_e;

endpackage

// File: rtl/pc_ras.sv
// Circular return-address stack. A push when full overwrites the oldest entry.
module pc_ras #(
    parameter int XLEN  = 32,
    parameter int DEPTH = 4
) (
    input  logic            Clk_i,
    input  logic            Rst_n_i,
    input  logic            Push_i,
    input  logic            Pop_i,
    input  logic [XLEN-1:0] PushData_i,
    output logic [XLEN-1:0] Top_o,
    output logic            Empty_o,
    output logic            Full_o
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [XLEN-1:0] mem [DEPTH];
    logic [PW-1:0]   ptr_reg;
    logic [CW-1:0]   count_reg;
    logic [PW-1:0]   top_idx;

    // ptr_reg points at the next free slot; the top lives one below it.
    assign top_idx = ptr_reg - PW'(1);
    assign Top_o   = mem[top_idx];
    assign Empty_o = (count_reg == '0);
    assign Full_o  = (count_reg == CW'(DEPTH));

    // Pointer and occupancy; count saturates while the pointer keeps wrapping.
    always_ff @(posedge Clk_i) begin
        if (!Rst_n_i) begin
            ptr_reg   <= '0;
            count_reg <= '0;
        end else if (Push_i) begin
            ptr_reg <= ptr_reg + PW'(1);
            if (!Full_o) count_reg <= count_reg + CW'(1);
        end else if (Pop_i && !Empty_o) begin
            ptr_reg   <= top_idx;
            count_reg <= count_reg - CW'(1);
        end
    end

    // Entry storage; contents need no reset since count gates their use.
    always_ff @(posedge Clk_i) begin
        if (Push_i) mem[ptr_reg] <= PushData_i;
    end

endmodule

// File: rtl/pc_sequencer.sv
// Fetch-stage PC: IDLE/RUN/HALT sequencer, priority redirect mux, RAS, alignment check.
module pc_sequencer
    import pc_pkg::*;
#(
    parameter int          XLEN      = 32,
    parameter logic [XLEN-1:0] RESET_VEC = '0,
    parameter logic [XLEN-1:0] TRAP_VEC  = XLEN'('h100),
    parameter int          INC       = 4,
    parameter int          RAS_DEPTH = 4
) (
    input  logic            Clk_i,
    input  logic            Rst_n_i,
    input  logic            Start_i,
    input  logic            Halt_i,
    input  logic            PCWrite_i,
    input  logic            Branch_i,
    input  logic [XLEN-1:0] BranchTarget_i,
    input  logic            Jump_i,
    input  logic [XLEN-1:0] JumpTarget_i,
    input  logic            Call_i,
    input  logic            Ret_i,
    input  logic            Trap_i,
    output logic [XLEN-1:0] PC_o,
    output logic            Valid_o,
    output logic [1:0]      State_o,
    output logic            RasEmpty_o,
    output logic            RasFull_o,
    output logic            Misaligned_o,
    output logic            RasUnderflow_o
);
    // Low bits that must be zero in any loaded target (empty mask when INC == 1).
    localparam logic [XLEN-1:0] ALIGN_MASK = XLEN'(INC - 1);

    pc_state_e       state_reg, state_next;
    pc_src_e         src;
    logic [XLEN-1:0] pc_reg, pc_next, pc_seq, ras_top;
    logic            mis_reg, mis_next, unf_reg, unf_next;
    logic            ras_push, ras_pop;

    assign pc_seq = pc_reg + XLEN'(INC);

    pc_ras #(.XLEN(XLEN), .DEPTH(RAS_DEPTH)) u_ras (
        .Clk_i      (Clk_i),
        .Rst_n_i    (Rst_n_i),
        .Push_i     (ras_push),
        .Pop_i      (ras_pop),
        .PushData_i (pc_seq),
        .Top_o      (ras_top),
        .Empty_o    (RasEmpty_o),
        .Full_o     (RasFull_o)
    );

    // Sequencer decision: next state, redirect source, RAS ops and pulse flags.
    always_comb begin
        state_next = state_reg;
        src        = SRC_HOLD;
        ras_push   = 1'b0;
        ras_pop    = 1'b0;
        mis_next   = 1'b0;
        unf_next   = 1'b0;
        unique case (state_reg)
            ST_IDLE: begin
                src = SRC_RESET;
                if (Start_i) state_next = ST_RUN;
            end
            ST_RUN: begin
                if (Trap_i) begin
                    src = SRC_TRAP;
                end else if (Halt_i) begin
                    state_next = ST_HALT;
                end else if (!PCWrite_i) begin
                    src = SRC_HOLD;
                end else if (Ret_i) begin
                    if (!RasEmpty_o) begin
                        src     = SRC_RET;
                        ras_pop = 1'b1;
                    end else begin
                        src      = SRC_SEQ;
                        unf_next = 1'b1;
                    end
                end else if (Jump_i) begin
                    src      = SRC_JUMP;
                    ras_push = Call_i;
                    mis_next = |(JumpTarget_i & ALIGN_MASK);
                end else if (Branch_i) begin
                    src      = SRC_BRANCH;
                    mis_next = |(BranchTarget_i & ALIGN_MASK);
                end else begin
                    src = SRC_SEQ;
                end
            end
            ST_HALT: begin
                if (Start_i) state_next = ST_RUN;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Next-PC mux driven by the selected redirect source.
    always_comb begin
        pc_next = pc_reg;
        unique case (src)
            SRC_SEQ:    pc_next = pc_seq;
            SRC_TRAP:   pc_next = TRAP_VEC;
            SRC_RET:    pc_next = ras_top;
            SRC_JUMP:   pc_next = JumpTarget_i & ~ALIGN_MASK;
            SRC_BRANCH: pc_next = BranchTarget_i & ~ALIGN_MASK;
            SRC_RESET:  pc_next = RESET_VEC;
            default:    pc_next = pc_reg;
        endcase
    end

    // State, PC and one-cycle pulse registers.
    always_ff @(posedge Clk_i) begin
        if (!Rst_n_i) begin
            state_reg <= ST_IDLE;
            pc_reg    <= RESET_VEC;
            mis_reg   <= 1'b0;
            unf_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            pc_reg    <= pc_next;
            mis_reg   <= mis_next;
            unf_reg   <= unf_next;
        end
    end

    assign PC_o           = pc_reg;
    assign State_o        = state_reg;
    assign Valid_o        = (state_reg == ST_RUN);
    assign Misaligned_o   = mis_reg;
    assign RasUnderflow_o = unf_reg;

endmodule
